a_seq_gen: RTL and testbench
============================

A_SEQ_GEN -- requirements
Module: a_seq_gen

Interface
REQ-001 Clock  input  1  single system clock; all state changes on its rising edge.
REQ-002 Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clock.
REQ-003 start  input  1  request for one full A sequence; sampled on each rising edge.
REQ-004 hold_len  input  4  phase length in cycles; captured only when a start is accepted.
REQ-005 K2  input  1  returned pulse from the downstream controller (Stop->Clear indication); sampled, not registered.
REQ-006 K1  input  1  returned pulse from the downstream controller (Clear->Idle indication); sampled, not registered.
REQ-007 A  output  1  generated control waveform; registered (Moore) output.
REQ-008 busy  output  1  high while a sequence is in progress.
REQ-009 done  output  1  one-cycle pulse marking the end of a sequence.
REQ-010 err  output  2  sticky mismatch flags: bit0 = K2 error, bit1 = K1 error.

Function
REQ-011 The block SHALL implement the states IDLE, PH0, PH1, PH2, PH3 and DONE.
REQ-012 A SHALL be 1 in PH0 and PH2, and 0 in IDLE, PH1, PH3 and DONE.
REQ-013 In IDLE, start=1 SHALL move the block to PH0, capture N = hold_len (hold_len = 0 captured as N = 1), and clear err to 00.
REQ-014 Each of PH0..PH3 SHALL last exactly N cycles, timed by a 4-bit down-counter reloaded on every phase entry.
REQ-015 Phase order SHALL be PH0 -> PH1 -> PH2 -> PH3 -> DONE -> IDLE; DONE SHALL last exactly 1 cycle.
REQ-016 A complete sequence SHALL take 4N+1 cycles, from the first PH0 cycle through the DONE cycle.
REQ-017 busy SHALL be 1 in PH0..PH3 and 0 in IDLE and DONE.
REQ-018 done SHALL be 1 only in DONE.
REQ-019 start SHALL be ignored in PH0..PH3 and DONE; there is no queueing.
REQ-020 start high in the DONE cycle SHALL NOT be accepted; a new start is accepted at the earliest in the following IDLE cycle.
REQ-021 Expected K2 window: the first cycle of PH2 only; K2=0 in that cycle, or K2=1 in any other non-IDLE cycle, SHALL set err[0].
REQ-022 Expected K1 window: the first cycle of PH3 only; K1=0 in that cycle, or K1=1 in any other non-IDLE cycle, SHALL set err[1].
REQ-023 K1 and K2 SHALL be ignored while in IDLE.
REQ-024 err bits SHALL be sticky: held through DONE and IDLE, and cleared only by reset or by an accepted start.
REQ-025 When an error occurs in the DONE cycle, err SHALL be updated on the edge leaving DONE, and done SHALL still pulse normally.
REQ-026 A simultaneous K1 and K2 error in the same cycle SHALL set both err bits.

Reset
REQ-027 With Reset=0 at a rising edge, the block SHALL enter IDLE and clear the counter and N.
REQ-028 On the same rising edge, the outputs SHALL become A=0, busy=0, done=0 and err=00.
REQ-029 Reset asserted mid-sequence SHALL abort the sequence: no done pulse, and A=0 from the next cycle.
REQ-030 Reset SHALL take priority over start in the same cycle.

Verification
REQ-031 Loopback to the downstream A-watching controller, hold_len=2, start pulse -> A=1,1,0,0,1,1,0,0; done in cycle 9; err=00; K2 seen in cycle 5; K1 seen in cycle 7.
REQ-032 hold_len=0, start -> each phase lasts 1 cycle; A=1,0,1,0; done in cycle 5; busy high in cycles 1-4.
REQ-033 K2 held 0 and K1 correct, hold_len=3 -> err=01 after the PH2 first cycle, still 01 after done; next start clears it to 00.
REQ-034 K1 forced 1 in PH0, hold_len=1 -> err[1]=1 immediately; sequence still completes with done after 5 cycles.
REQ-035 start held high continuously, hold_len=1 -> sequences separated by DONE plus one IDLE cycle; no start accepted in the DONE cycle.
REQ-036 Reset=0 during PH2 with hold_len=4 -> next cycle A=0, busy=0, err=00; no done pulse; the following start runs a full sequence.

Source files
------------

// File: rtl/a_seq_gen_if.sv
// Signal bundle between the A-sequence generator and its downstream controller.
// slave = generator side, master = controller/stimulus side.
interface a_seq_gen_if;
  logic       start;
  logic [3:0] hold_len;
  logic       K2;
  logic       K1;
  logic       A;
  logic       busy;
  logic       done;
  logic [1:0] err;

  modport master (
    output start, hold_len, K2, K1,
    input  A, busy, done, err
  );

  modport slave (
    input  start, hold_len, K2, K1,
    output A, busy, done, err
  );
endinterface

// File: rtl/a_seq_gen.sv
// Generates one A waveform (four phases of N cycles each, then a one-cycle DONE) per accepted start.
// Outputs are registered (Moore). A start is only taken in IDLE; starts seen in any other state are dropped, not queued.
module a_seq_gen (
  input  logic       Clock,
  input  logic       Reset,
  a_seq_gen_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PH0, PH1, PH2, PH3, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] n;
  logic       a_q;
  logic       busy_q;
  logic       done_q;
  logic [1:0] err_q;

  logic [3:0] n_sel;
  logic       first;
  logic       phase_end;
  logic       k2_bad;
  logic       k1_bad;

  always_comb begin
    n_sel     = (bus.hold_len == 4'd0) ? 4'd1 : bus.hold_len;
    first     = (cnt == n);
    phase_end = (cnt == 4'd1);
    // Each K pulse is legal only in the first cycle of its phase; anywhere else it is an error.
    k2_bad    = (state == PH2 && first) ? ~bus.K2 : bus.K2;
    k1_bad    = (state == PH3 && first) ? ~bus.K1 : bus.K1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      n      <= 4'd0;
      a_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 2'b00;
    end else begin
      if (state != IDLE)
        err_q <= err_q | {k1_bad, k2_bad};

      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= PH0;
            n      <= n_sel;
            cnt    <= n_sel;
            a_q    <= 1'b1;
            busy_q <= 1'b1;
            err_q  <= 2'b00;
          end
        end
        PH0: begin
          if (phase_end) begin
            state <= PH1;
            cnt   <= n;
            a_q   <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PH1: begin
          if (phase_end) begin
            state <= PH2;
            cnt   <= n;
            a_q   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PH2: begin
          if (phase_end) begin
            state <= PH3;
            cnt   <= n;
            a_q   <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PH3: begin
          if (phase_end) begin
            state  <= DONE;
            cnt    <= n;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          a_q    <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.A    = a_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_a_seq_gen.sv
// Drives a_seq_gen with directed and random traffic and scores it against a
// position-in-sequence model (cycle p of 4N+1) rather than a state machine.
module tb_a_seq_gen;
  logic Clock = 1'b0;
  logic Reset = 1'b0;

  a_seq_gen_if bus();

  a_seq_gen dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: m_p = 0 means idle, otherwise the 1-based cycle within the current sequence.
  int         m_p   = 0;
  int         m_n   = 0;
  logic [1:0] m_err = 2'b00;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic lb_k2();
    return (m_p != 0) && (m_p == 2 * m_n + 1);
  endfunction

  function automatic logic lb_k1();
    return (m_p != 0) && (m_p == 3 * m_n + 1);
  endfunction

  task automatic step(input logic rst, input logic st, input logic [3:0] hl,
                      input logic k2, input logic k1);
    logic exp_a, exp_busy, exp_done;
    Reset        = rst;
    bus.start    = st;
    bus.hold_len = hl;
    bus.K2       = k2;
    bus.K1       = k1;
    @(posedge Clock);
    if (!rst) begin
      m_p   = 0;
      m_n   = 0;
      m_err = 2'b00;
    end else if (m_p == 0) begin
      if (st) begin
        m_n   = (hl == 4'd0) ? 1 : int'(hl);
        m_p   = 1;
        m_err = 2'b00;
      end
    end else begin
      if (k2 != (m_p == 2 * m_n + 1)) m_err[0] = 1'b1;
      if (k1 != (m_p == 3 * m_n + 1)) m_err[1] = 1'b1;
      m_p = (m_p == 4 * m_n + 1) ? 0 : m_p + 1;
    end
    #1;
    exp_busy = (m_p >= 1) && (m_p <= 4 * m_n);
    exp_a    = exp_busy && (((m_p - 1) / m_n) % 2 == 0);
    exp_done = (m_p != 0) && (m_p == 4 * m_n + 1);
    check_eq("A",    bus.A,    exp_a);
    check_eq("busy", bus.busy, exp_busy);
    check_eq("done", bus.done, exp_done);
    check_eq("err",  bus.err,  m_err);
  endtask

  // Well-behaved downstream controller answering exactly in its windows.
  task automatic run(input logic st, input logic [3:0] hl, input int cycles);
    for (int i = 0; i < cycles; i++)
      step(1'b1, st, hl, lb_k2(), lb_k1());
  endtask

  initial begin
    logic [7:0] a_hist;

    step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
    check_eq("rst_all", {bus.A, bus.busy, bus.done, bus.err}, 8'h00);
    run(1'b0, 4'd0, 2);

    // Loopback, N=2: A = 11001100, done in cycle 9, no errors.
    step(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
    a_hist = {7'd0, bus.A};
    for (int i = 0; i < 7; i++) begin
      run(1'b0, 4'd2, 1);
      a_hist = {a_hist[6:0], bus.A};
    end
    check_eq("lb_a_pattern", a_hist, 8'hCC);
    run(1'b0, 4'd2, 1);
    check_eq("lb_done_c9", bus.done, 8'd1);
    check_eq("lb_err", bus.err, 8'd0);
    run(1'b0, 4'd2, 2);

    // hold_len = 0 behaves as N = 1.
    step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    run(1'b0, 4'd0, 5);

    // K2 stuck low: err = 01, sticky past done, cleared by next start.
    step(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++)
      step(1'b1, 1'b0, 4'd3, 1'b0, lb_k1());
    check_eq("k2_sticky", bus.err, 8'd1);
    step(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    check_eq("start_clr", bus.err, 8'd0);
    run(1'b0, 4'd1, 5);

    // K1 forced high in PH0 with N = 1.
    step(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd1, lb_k2(), 1'b1);
    check_eq("k1_early", bus.err[1], 8'd1);
    run(1'b0, 4'd1, 3);
    check_eq("k1_done", bus.done, 8'd1);
    run(1'b0, 4'd1, 1);

    // start held high: back-to-back sequences with one IDLE gap.
    run(1'b1, 4'd1, 24);
    run(1'b0, 4'd1, 6);

    // Reset in PH2 aborts the sequence; then a full sequence runs.
    step(1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
    run(1'b0, 4'd4, 9);
    step(1'b0, 1'b0, 4'd4, lb_k2(), lb_k1());
    check_eq("abort_out", {bus.A, bus.busy, bus.done, bus.err}, 8'h00);
    step(1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
    run(1'b0, 4'd4, 17);

    for (int i = 0; i < 3000; i++) begin
      logic       r_rst, r_st, r_k2, r_k1;
      logic [3:0] r_hl;
      r_rst = ($urandom % 300) != 0;
      r_st  = ($urandom % 3) == 0;
      r_hl  = 4'($urandom);
      r_k2  = lb_k2() ^ (($urandom % 20) == 0);
      r_k1  = lb_k1() ^ (($urandom % 20) == 0);
      step(r_rst, r_st, r_hl, r_k2, r_k1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
